unified_mem: RTL and testbench
==============================

UNIFIED_MEM -- requirements
Module: unified_mem

Interface
REQ-001 SHALL provide parameter DEPTH_LOG2, default 10, log2 of memory depth in 32-bit words.
REQ-002 SHALL provide parameter WAIT, default 1, extra wait cycles per access, legal range 0..15.
REQ-003 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port i_ce  input  1  instruction fetch request.
REQ-006 SHALL provide port i_addr  input  32  fetch byte address.
REQ-007 SHALL provide port i_rdata  output  32  fetch read data.
REQ-008 SHALL provide port i_ready  output  1  fetch completion pulse.
REQ-009 SHALL provide port d_ce  input  1  data request.
REQ-010 SHALL provide port d_we  input  1  data write enable (1 = write, 0 = read).
REQ-011 SHALL provide port d_sel  input  4  byte lane enables, bit i covers bits 8i+7:8i.
REQ-012 SHALL provide port d_addr  input  32  data byte address.
REQ-013 SHALL provide port d_wdata  input  32  data write data.
REQ-014 SHALL provide port d_rdata  output  32  data read data.
REQ-015 SHALL provide port d_ready  output  1  data completion pulse.

Function
REQ-016 SHALL hold one shared array of 2^DEPTH_LOG2 words; word index = addr[DEPTH_LOG2+1:2]; addr[1:0] and higher bits ignored, so out-of-range addresses alias.
REQ-017 SHALL implement FSM states IDLE, WAITING, ACCESS.
REQ-018 IDLE: if any ce is high at the edge, grant one port, latch its address/we/sel/wdata, then go to WAITING (WAIT>0, counter loaded with WAIT) or ACCESS (WAIT=0); otherwise stay in IDLE.
REQ-019 WAITING: counter decrements each cycle; go to ACCESS at the edge where the counter reaches 1.
REQ-020 Memory access SHALL happen at the edge entering ACCESS: read loads the granted port's rdata register; write updates only the lanes whose d_sel bit is set.
REQ-021 ACCESS SHALL last exactly one cycle with the granted port's ready = 1; ce is ignored in ACCESS; the next state is always IDLE.
REQ-022 Latency: ce sampled in IDLE cycle 0 -> ready high in cycle 1+WAIT; throughput is one transaction per 2+WAIT cycles.
REQ-023 Requesters SHALL hold address, we, sel and wdata stable from ce assertion until ready; the block uses the values latched at grant.
REQ-024 The instruction port SHALL be read-only.
REQ-025 A read SHALL return the full word regardless of d_sel; a write with d_sel = 0000 SHALL leave memory unchanged and still pulse d_ready.
REQ-026 Each rdata register SHALL update only on its own port's read and SHALL hold its value otherwise.
REQ-027 i_ready and d_ready SHALL never be high in the same cycle.
REQ-028 If both ports request in IDLE, arbitration SHALL follow REQ-034/035; the losing port's request stays pending and is granted in the next IDLE cycle if its ce is still high.

Reset
REQ-029 While rst = 0: state = IDLE, i_ready = 0, d_ready = 0, i_rdata = 0, d_rdata = 0, wait counter = 0, round-robin pointer = "data next".
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset asserted before the ACCESS-entry edge SHALL abort the transaction with no memory write and no ready pulse.
REQ-032 After rst deasserts, the first request SHALL be sampled at the first rising edge.

Configuration
REQ-033 SHALL recognise macro UMEM_RR_ARB_EN.
REQ-034 Without UMEM_RR_ARB_EN: on contention the data port SHALL always win (fixed priority).
REQ-035 With UMEM_RR_ARB_EN: on contention the port not granted most recently SHALL win; the pointer SHALL update on every grant and starts at "data next" after reset.

Verification
REQ-036 WAIT=0: write 0xDEADBEEF to 0x10 with sel 1111, then fetch 0x10 -> i_ready in cycle 1 after the fetch ce, i_rdata = 0xDEADBEEF.
REQ-037 Word 0x11223344 at 0x20, write sel 0010 with wdata 0x0000AA00, then read -> d_rdata = 0x1122AA44.
REQ-038 WAIT=2, no macro, i_ce and d_ce both high in cycle 0 and held -> d_ready in cycle 3, i_ready in cycle 7, never overlapping.
REQ-039 With UMEM_RR_ARB_EN, both ce held high continuously -> grant order D, I, D, I, with ready pulses every 2+WAIT cycles.
REQ-040 WAIT=3, write 0x55 to 0x0, assert rst in the second WAITING cycle -> memory unchanged, no d_ready, outputs 0, FSM in IDLE.
REQ-041 DEPTH_LOG2=4: write 0xCAFEF00D to 0x40, then read 0x00 -> d_rdata = 0xCAFEF00D.

Source files
------------

// File: rtl/unified_mem.sv
// Shared instruction/data word memory with a wait-state FSM and two-port arbitration.
// Define UMEM_RR_ARB_EN for round-robin arbitration; fixed data-port priority otherwise.
module unified_mem #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ce,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_ce,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [1:0]  o_state
);

    // Handshake: a requester raises ce and holds addr/we/sel/wdata stable until
    // its ready pulses for exactly one cycle; ready is the only completion signal.

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_L   = 4'(WAIT);
    localparam bit         HAS_WAIT = (WAIT != 0);

    // o_state encoding: 0 = IDLE, 1 = WAITING, 2 = ACCESS
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        ACCESS  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_wait_cnt;
    logic                    r_gnt_d;
    logic                    r_we;
    logic [3:0]              r_sel;
    logic [31:0]             r_wdata;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [31:0]             r_i_rdata;
    logic [31:0]             r_d_rdata;
    logic                    r_i_ready;
    logic                    r_d_ready;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_grant;
    logic                    w_grant_d;
    logic                    w_prio_d;
    logic                    w_enter_access;
    logic                    w_acc_d;
    logic                    w_acc_we;
    logic [3:0]              w_acc_sel;
    logic [31:0]             w_acc_wdata;
    logic [DEPTH_LOG2-1:0]   w_acc_idx;
    logic                    w_unused_addr;

    assign w_unused_addr = ^{i_addr[31:DEPTH_LOG2+2], i_addr[1:0],
                             d_addr[31:DEPTH_LOG2+2], d_addr[1:0]};

`ifdef UMEM_RR_ARB_EN
    // Set when the data port should win the next contention.
    logic r_rr_data_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_data_next <= 1'b1;
        end else if (w_grant) begin
            r_rr_data_next <= !w_grant_d;
        end
    end

    assign w_prio_d = r_rr_data_next;
`else
    assign w_prio_d = 1'b1;
`endif

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_ce || d_ce) begin
                    w_grant   = 1'b1;
                    w_grant_d = d_ce && (!i_ce || w_prio_d);
                    if (HAS_WAIT) begin
                        w_state_next = WAITING;
                    end else begin
                        w_state_next = ACCESS;
                    end
                end
            end
            WAITING: begin
                if (r_wait_cnt == 4'd1) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_enter_access = (w_state_next == ACCESS) && (r_state != ACCESS);

    // With no wait states the access happens on the grant edge, so it must use the live request.
    always_comb begin
        w_acc_d     = r_gnt_d;
        w_acc_we    = r_we;
        w_acc_sel   = r_sel;
        w_acc_wdata = r_wdata;
        w_acc_idx   = r_idx;
        if (r_state == IDLE) begin
            w_acc_d     = w_grant_d;
            w_acc_we    = d_we;
            w_acc_sel   = d_sel;
            w_acc_wdata = d_wdata;
            w_acc_idx   = w_grant_d ? d_addr[DEPTH_LOG2+1:2] : i_addr[DEPTH_LOG2+1:2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_gnt_d    <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= 4'd0;
            r_wdata    <= 32'd0;
            r_idx      <= '0;
            r_i_rdata  <= 32'd0;
            r_d_rdata  <= 32'd0;
            r_i_ready  <= 1'b0;
            r_d_ready  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_gnt_d    <= w_grant_d;
                r_we       <= d_we;
                r_sel      <= d_sel;
                r_wdata    <= d_wdata;
                r_idx      <= w_acc_idx;
                r_wait_cnt <= WAIT_L;
            end else if (r_state == WAITING) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            r_i_ready <= w_enter_access && !w_acc_d;
            r_d_ready <= w_enter_access && w_acc_d;
            if (w_enter_access && !w_acc_d) begin
                r_i_rdata <= r_mem[w_acc_idx];
            end
            if (w_enter_access && w_acc_d && !w_acc_we) begin
                r_d_rdata <= r_mem[w_acc_idx];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_enter_access && w_acc_d && w_acc_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_sel[b]) begin
                    r_mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_ready = r_i_ready;
    assign d_ready = r_d_ready;
    assign o_state = r_state;

endmodule

// File: tb/tb_unified_mem.sv
// Self-checking bench for unified_mem: vector table, hand sequences and a
// randomized run against a transaction-level memory/arbitration model.
module tb_unified_mem;

    localparam int W       = 2;
    localparam int DL      = 4;
    localparam int NWORDS  = 16;
    localparam int TIMEOUT = 40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main DUT: WAIT=2, 16 words
    logic        i_ce = 0, d_ce = 0, d_we = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [3:0]  d_sel = 0;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ready, d_ready;
    logic [1:0]  o_state;

    unified_mem #(.DEPTH_LOG2(DL), .WAIT(W)) dut (
        .clk(clk), .rst(rst),
        .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_ce(d_ce), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .o_state(o_state)
    );

    // second DUT: WAIT=0, default depth
    logic        z_i_ce = 0, z_d_ce = 0, z_d_we = 0;
    logic [31:0] z_i_addr = 0, z_d_addr = 0, z_d_wdata = 0;
    logic [3:0]  z_d_sel = 0;
    logic [31:0] z_i_rdata, z_d_rdata;
    logic        z_i_ready, z_d_ready;
    logic [1:0]  z_state;

    unified_mem #(.DEPTH_LOG2(10), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_ce(z_i_ce), .i_addr(z_i_addr), .i_rdata(z_i_rdata), .i_ready(z_i_ready),
        .d_ce(z_d_ce), .d_we(z_d_we), .d_sel(z_d_sel), .d_addr(z_d_addr),
        .d_wdata(z_d_wdata), .d_rdata(z_d_rdata), .d_ready(z_d_ready),
        .o_state(z_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [NWORDS];
    logic [31:0] m_last_i = 0;
    logic [31:0] m_last_d = 0;
    bit          m_last_was_d = 0;

    function automatic logic [31:0] m_do(bit is_d, bit we, logic [3:0] sel,
                                         logic [31:0] addr, logic [31:0] wd);
        int idx;
        idx = int'((addr / 4) % NWORDS);
        m_last_was_d = is_d;
        if (is_d && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
            return m_last_d;
        end
        if (is_d) m_last_d = m_mem[idx];
        else      m_last_i = m_mem[idx];
        return m_mem[idx];
    endfunction

    function automatic bit m_data_wins();
`ifdef UMEM_RR_ARB_EN
        return !m_last_was_d;
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn(input bit ri, input bit rd, input logic [31:0] ia,
                           input bit we, input logic [3:0] sel, input logic [31:0] da,
                           input logic [31:0] wd, output int ilat, output int dlat,
                           output logic [31:0] idat, output logic [31:0] ddat);
        bit pend_i, pend_d, both, spur;
        ilat = -1; dlat = -1; idat = 0; ddat = 0;
        pend_i = ri; pend_d = rd; both = 0; spur = 0;
        i_ce = ri; i_addr = ia;
        d_ce = rd; d_we = we; d_sel = sel; d_addr = da; d_wdata = wd;
        for (int c = 1; c <= TIMEOUT && (pend_i || pend_d); c++) begin
            @(posedge clk); @(negedge clk);
            if (i_ready && d_ready) both = 1;
            if (i_ready) begin
                if (pend_i) begin ilat = c; idat = i_rdata; pend_i = 0; i_ce = 0; end
                else spur = 1;
            end
            if (d_ready) begin
                if (pend_d) begin dlat = c; ddat = d_rdata; pend_d = 0; d_ce = 0; end
                else spur = 1;
            end
        end
        check("ready_overlap", 32'(both), 32'd0);
        check("spurious_ready", 32'(spur), 32'd0);
        check("txn_timeout", {30'd0, pend_i, pend_d}, 32'd0);
        i_ce = 0; d_ce = 0;
        @(posedge clk); @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[11];

    int ilat, dlat, nev;
    logic [31:0] idat, ddat, e_i, e_d;
    bit  rw, win_d, r_i, r_d, spur, both;
    logic [3:0] rsel;
    logic [31:0] ra_i, ra_d, rwd;
    int mode;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1, 1, 4'b1111, 32'h0000_0020, 32'h1122_3344, 32'h0};
        tbl[1]  = '{1, 1, 4'b0010, 32'h0000_0020, 32'h0000_AA00, 32'h0};
        tbl[2]  = '{1, 0, 4'b0000, 32'h0000_0020, 32'h0,         32'h1122_AA44};
        tbl[3]  = '{1, 1, 4'b1111, 32'h0000_0040, 32'hCAFE_F00D, 32'h0};
        tbl[4]  = '{1, 0, 4'b1111, 32'h0000_0000, 32'h0,         32'hCAFE_F00D};
        tbl[5]  = '{1, 1, 4'b0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{0, 0, 4'b0000, 32'h0000_0040, 32'h0,         32'hCAFE_F00D};
        tbl[7]  = '{1, 1, 4'b1111, 32'h0000_0024, 32'h0102_0304, 32'h0};
        tbl[8]  = '{1, 1, 4'b1001, 32'h0000_0024, 32'hAB00_00CD, 32'h0};
        tbl[9]  = '{0, 0, 4'b0000, 32'h0000_0027, 32'h0,         32'hAB02_03CD};
        tbl[10] = '{1, 0, 4'b1111, 32'h1000_0024, 32'h0,         32'hAB02_03CD};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // WAIT=0 write then fetch
        z_d_ce = 1; z_d_we = 1; z_d_sel = 4'hF; z_d_addr = 32'h10; z_d_wdata = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        check("w0_d_ready", 32'(z_d_ready), 32'd1);
        z_d_ce = 0;
        @(posedge clk); @(negedge clk);
        z_i_ce = 1; z_i_addr = 32'h10;
        @(posedge clk); @(negedge clk);
        check("w0_i_ready", 32'(z_i_ready), 32'd1);
        check("w0_i_rdata", z_i_rdata, 32'hDEAD_BEEF);
        z_i_ce = 0;
        @(posedge clk); @(negedge clk);

        // fill the main memory so the model is fully defined
        for (int k = 0; k < NWORDS; k++) begin
            rwd = $urandom;
            run_txn(0, 1, 0, 1, 4'hF, 32'(k * 4), rwd, ilat, dlat, idat, ddat);
            void'(m_do(1, 1, 4'hF, 32'(k * 4), rwd));
            check("init_lat", 32'(dlat), 32'(1 + W));
        end

        // table of single-port vectors
        for (int v = 0; v < 11; v++) begin
            run_txn(!tbl[v].is_d, tbl[v].is_d, tbl[v].addr, tbl[v].we, tbl[v].sel,
                    tbl[v].addr, tbl[v].wdata, ilat, dlat, idat, ddat);
            void'(m_do(tbl[v].is_d, tbl[v].we, tbl[v].sel, tbl[v].addr, tbl[v].wdata));
            if (tbl[v].is_d) begin
                check($sformatf("vec%0d_lat", v), 32'(dlat), 32'(1 + W));
                if (!tbl[v].we) check($sformatf("vec%0d_data", v), ddat, tbl[v].exp);
            end else begin
                check($sformatf("vec%0d_lat", v), 32'(ilat), 32'(1 + W));
                check($sformatf("vec%0d_data", v), idat, tbl[v].exp);
            end
            check("hold_i", i_rdata, m_last_i);
            check("hold_d", d_rdata, m_last_d);
        end

        // reset during the second WAITING cycle aborts a write
        d_ce = 1; d_we = 1; d_sel = 4'hF; d_addr = 32'h0; d_wdata = 32'h55;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_state", 32'(o_state), 32'd0);
        check("abort_d_ready", 32'(d_ready), 32'd0);
        check("abort_d_rdata", d_rdata, 32'd0);
        check("abort_i_rdata", i_rdata, 32'd0);
        d_ce = 0;
        spur = 0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            if (d_ready || i_ready) spur = 1;
        end
        check("abort_no_ready", 32'(spur), 32'd0);
        m_last_i = 0; m_last_d = 0; m_last_was_d = 0;
        rst = 1'b1;
        run_txn(0, 1, 0, 0, 4'hF, 32'h0, 0, ilat, dlat, idat, ddat);
        e_d = m_do(1, 0, 4'hF, 32'h0, 0);
        check("abort_first_lat", 32'(dlat), 32'(1 + W));
        check("abort_mem_kept", ddat, e_d);

        // both ports held continuously: grant order and pulse spacing
        for (int g = 0; g < 4; g++) begin
`ifdef UMEM_RR_ARB_EN
            exp_q.push_back({(g % 2 == 0) ? 1'b1 : 1'b0, 8'(1 + W + g * (2 + W))});
`else
            exp_q.push_back({1'b1, 8'(1 + W + g * (2 + W))});
`endif
        end
        i_ce = 1; i_addr = 32'hC; d_ce = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h8;
        nev = 0; both = 0;
        for (int c = 1; c <= 30 && nev < 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (i_ready && d_ready) both = 1;
            if (i_ready || d_ready) begin
                nev++;
                if (exp_q.size() == 0) check("cont_extra", 32'(c), 32'd0);
                else check("cont_order", {23'd0, d_ready, 8'(c)}, {23'd0, exp_q.pop_front()});
                if (d_ready) check("cont_d_data", d_rdata, m_do(1, 0, 4'hF, 32'h8, 0));
                else         check("cont_i_data", i_rdata, m_do(0, 0, 4'h0, 32'hC, 0));
                if (nev == 4) begin i_ce = 0; d_ce = 0; end
            end
        end
        i_ce = 0; d_ce = 0;
        check("cont_overlap", 32'(both), 32'd0);
        check("cont_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk); @(negedge clk);

        // simultaneous request released after each completion
        win_d = m_data_wins();
        run_txn(1, 1, 32'h4, 0, 4'hF, 32'h0, 0, ilat, dlat, idat, ddat);
        if (win_d) begin
            e_d = m_do(1, 0, 4'hF, 32'h0, 0);
            e_i = m_do(0, 0, 4'h0, 32'h4, 0);
        end else begin
            e_i = m_do(0, 0, 4'h0, 32'h4, 0);
            e_d = m_do(1, 0, 4'hF, 32'h0, 0);
        end
        check("both_d_lat", 32'(dlat), win_d ? 32'(1 + W) : 32'(3 + 2 * W));
        check("both_i_lat", 32'(ilat), win_d ? 32'(3 + 2 * W) : 32'(1 + W));
        check("both_d_data", ddat, e_d);
        check("both_i_data", idat, e_i);

        // randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            mode = $urandom_range(0, 2);
            r_i  = (mode != 1);
            r_d  = (mode != 0);
            rw   = $urandom_range(0, 1);
            rsel = 4'($urandom);
            ra_i = $urandom;
            ra_d = $urandom;
            rwd  = $urandom;
            win_d = r_d && (!r_i || m_data_wins());
            run_txn(r_i, r_d, ra_i, rw, rsel, ra_d, rwd, ilat, dlat, idat, ddat);
            e_i = 0; e_d = 0;
            if (win_d) begin
                e_d = m_do(1, rw, rsel, ra_d, rwd);
                if (r_i) e_i = m_do(0, 0, 4'h0, ra_i, 0);
            end else begin
                e_i = m_do(0, 0, 4'h0, ra_i, 0);
                if (r_d) e_d = m_do(1, rw, rsel, ra_d, rwd);
            end
            check("rnd_i_lat", 32'(ilat),
                  !r_i ? 32'hFFFF_FFFF : (win_d ? 32'(3 + 2 * W) : 32'(1 + W)));
            check("rnd_d_lat", 32'(dlat),
                  !r_d ? 32'hFFFF_FFFF : (win_d ? 32'(1 + W) : 32'(3 + 2 * W)));
            if (r_i) check("rnd_i_data", idat, e_i);
            if (r_d && !rw) check("rnd_d_data", ddat, e_d);
            check("rnd_hold_i", i_rdata, m_last_i);
            check("rnd_hold_d", d_rdata, m_last_d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
